// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing defaults, derived constants and the coordinate type.
// Parameterised blocks take these as defaults and derive their own totals from overrides.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that lines sync pulses up with registered colour downstream.
// DEPTH=0 is a plain wire; stages reset to RST_VAL and hold while en_i is low.
module vga_sync_delay #(
  parameter int unsigned      WIDTH   = 2,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_bypass
    assign dout_o = din_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          sr_q[i] <= RST_VAL;
        end
      end else if (en_i) begin
        sr_q[0] <= din_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign dout_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with flags registered from next-state counts so they never lag DrawX/DrawY.
// Holds everything (strobes forced low) while enable is low; hs_d/vs_d trail hs/vs by PIPE_DELAY.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned PIPE_DELAY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t H_SS    = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SE    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SS    = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SE    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic   SYNC_IDLE = ~SYNC_ACTIVE;

  coord_t     hc_q, hc_d;
  coord_t     vc_q, vc_d;
  logic       blank_q, blank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;
  logic [7:0] fcount_q, fcount_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (enable) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? coord_t'(0) : vc_q + coord_t'(1);
      end else begin
        hc_d = hc_q + coord_t'(1);
      end
    end
  end

  // Level flags decode the next counts, so a frozen counter yields frozen flags for free.
  always_comb begin
    blank_d  = (hc_d < H_VIS) && (vc_d < V_VIS);
    hsync_d  = in_window(hc_d, H_SS, H_SE) ? SYNC_ACTIVE : SYNC_IDLE;
    vsync_d  = in_window(vc_d, V_SS, V_SE) ? SYNC_ACTIVE : SYNC_IDLE;
    line_d   = enable && (hc_d == '0);
    frame_d  = line_d && (vc_d == '0);
    fcount_d = frame_d ? fcount_q + 8'd1 : fcount_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q     <= H_LAST;
      vc_q     <= V_LAST;
      blank_q  <= 1'b0;
      hsync_q  <= SYNC_IDLE;
      vsync_q  <= SYNC_IDLE;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= 8'hFF;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      blank_q  <= blank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fcount_q <= fcount_d;
    end
  end

  vga_sync_delay #(
    .WIDTH   (2),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .en_i   (enable),
    .din_i  ({hsync_q, vsync_q}),
    .dout_o ({hs_d, vs_d})
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fcount_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It is the stage directly upstream of every sprite/background renderer: it drives DrawX, DrawY and blank, and produces hs/vs delayed to line up with the renderers' one-cycle registered colour output. It also provides line/frame strobes and a frame counter for animation stepping.

## Interface
Parameters:
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch
- H_SYNC, 96: hsync width
- H_BACK, 48: horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480: visible lines
- V_FRONT, 10: vertical front porch
- V_SYNC, 2: vsync width
- V_BACK, 33: vertical back porch (V_TOTAL = 525)
- SYNC_ACTIVE, 1'b0: asserted sync level (active-low)
- PIPE_DELAY, 1: extra cycles applied to hs_d/vs_d (0..4)

Ports:
- vga_clk  in  1  pixel clock. Only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = raster advances; 0 = freeze.
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1.
- DrawY  out  10  current vertical count, 0..V_TOTAL-1.
- blank  out  1  1 = pixel visible (DrawX<H_VISIBLE and DrawY<V_VISIBLE).
- hs, vs  out  1  syncs aligned with DrawX/DrawY.
- hs_d, vs_d  out  1  hs/vs delayed PIPE_DELAY cycles, for the monitor pins.
- line_start  out  1  one-cycle pulse when DrawX==0.
- frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0.
- frame_count  out  8  frames started, mod 256.

## Operation
- Horizontal counter hc counts 0..H_TOTAL-1 and wraps to 0. The vertical counter vc increments only on the hc wrap. vc counts 0..V_TOTAL-1 and wraps to 0.
- DrawX = hc and DrawY = vc. Both are unclamped, so they run through the porches.
- hs = SYNC_ACTIVE while hc is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751. Otherwise hs = ~SYNC_ACTIVE.
- vs = SYNC_ACTIVE while vc is in 490..491, for whole lines.
- hs, vs, blank, line_start and frame_start are flops loaded from the next-state counter values. They change on the same edge as DrawX/DrawY, with no decode glitches.
- frame_count increments on the edge that asserts frame_start. It wraps 255→0.
- hs_d/vs_d: a PIPE_DELAY-deep shift register fed from hs/vs. Reset fill is ~SYNC_ACTIVE. With PIPE_DELAY=0 they equal hs/vs.
- enable=0 behaviour:
  - Counters, level outputs and the delay line hold.
  - line_start and frame_start read 0.
  - When enable returns to 1, the next edge advances normally.

## Timing
- Reset (async assert) values:
  - hc=H_TOTAL-1, vc=V_TOTAL-1, so DrawX=799 and DrawY=524.
  - blank=0.
  - hs, vs, hs_d, vs_d = ~SYNC_ACTIVE.
  - line_start=0, frame_start=0.
  - frame_count=8'hFF.
- First rising edge after release with enable=1:
  - DrawX=0, DrawY=0, blank=1.
  - line_start=1, frame_start=1, frame_count=0.
- Latency from counter to flags is 0 cycles: flags always describe the DrawX/DrawY present in the same cycle.
- Downstream renderers register colour one cycle after DrawX/DrawY, so hs_d/vs_d (PIPE_DELAY=1) match the colour outputs.
- Line wrap: on the edge where DrawX goes 799→0, DrawY increments in the same edge.
- Frame wrap: DrawX 799→0 and DrawY 524→0 happen in a single edge.
- Reset asserted mid-frame: all outputs take their reset values immediately. The restart behaves exactly like power-up.
- Frame period: 420000 enabled cycles.

## Structure
- Package vga_pkg holds:
  - the timing defaults, derived H_TOTAL/V_TOTAL and sync start/end constants;
  - a typedef for the 10-bit coordinate.
- Sub-module vga_sync_delay: a parameterised shift register for hs_d/vs_d, with reset fill value as a parameter.
- Both counters stay inline.

## Test plan
- Reset: hold reset_n=0 → DrawX=799, DrawY=524, blank=0, hs=vs=1, frame_count=255. First edge after release → (0,0), blank=1, frame_start=1, frame_count=0.
- Line sweep:
  - hs=0 exactly for DrawX 656..751 (96 cycles).
  - blank=0 from DrawX 640 on.
  - DrawX 799→0 coincides with a DrawY increment and line_start=1.
- Frame sweep:
  - vs=0 exactly for DrawY 490..491 (1600 cycles).
  - blank=0 for DrawY ≥480.
  - frame_start pulses every 420000 cycles.
- Frame counter: run 256 frames → frame_count wraps 255→0 with no skipped value.
- Enable hold: drop enable at DrawX=700 for 10 cycles → all outputs frozen, strobes 0. After release, DrawX=701 on the next edge.
- Delay/reset: with PIPE_DELAY=1, hs_d equals hs delayed one cycle. Assert reset_n at DrawY=300 → immediate reset values, clean restart at (0,0).
